// File: rtl/sram_lsu.sv
// sram_lsu: load/store unit issuing registered SRAM accesses and tracking loads to tagged write-back
module sram_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20,
  parameter int READ_LATENCY = 2,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      inst_valid,
  input  logic [31:0]               inst,
  input  logic [DATA_WIDTH-1:0]     rs,
  input  logic [DATA_WIDTH-1:0]     rt,
  input  logic [DATA_WIDTH-1:0]     imm,
  input  logic [DATA_WIDTH-1:0]     sram_rdata,
  output logic                      sram_en,
  output logic                      sram_we,
  output logic [ADDR_WIDTH-1:0]     sram_addr,
  output logic [DATA_WIDTH-1:0]     sram_wdata,
  output logic                      wb_enable,
  output logic [REG_ADDR_WIDTH-1:0] wb_addr,
  output logic                      wb_float,
  output logic [DATA_WIDTH-1:0]     wb_data,
  input  logic [REG_ADDR_WIDTH-1:0] query_addr,
  input  logic                      query_float,
  output logic                      query_hit,
  output logic [3:0]                inflight
);
  logic [5:0] op;
  logic is_ld, is_st, acc, tag_v;
  logic [REG_ADDR_WIDTH-1:0] dest;
  logic [DATA_WIDTH-1:0] sum;
  logic [READ_LATENCY:0] v, f, nv;
  logic [REG_ADDR_WIDTH-1:0] d [READ_LATENCY+1];
  logic unused;
  assign op = inst[31:26];
  assign is_ld = inst_valid && (op == 6'b101000 || op == 6'b101100 || op == 6'b101010 || op == 6'b101110);
  assign is_st = inst_valid && (op == 6'b101001 || op == 6'b101011);
  assign acc = is_ld || is_st;
  // op[2] selects the register form (rt index, rd dest); op[1] selects the FP file
  assign dest = REG_ADDR_WIDTH'(op[2] ? inst[15:11] : inst[20:16]);
  assign sum = rs + (op[2] ? rt : imm);
  assign tag_v = is_ld && (op[1] || dest != '0);
  assign nv = {v[READ_LATENCY-1:0], tag_v};
  assign unused = ^{inst[25:21], inst[10:0]};
  assign wb_enable = v[READ_LATENCY];
  assign wb_addr = d[READ_LATENCY];
  assign wb_float = f[READ_LATENCY];
  assign wb_data = sram_rdata;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sram_en <= 1'b0;
      sram_we <= 1'b0;
      sram_addr <= '0;
      sram_wdata <= '0;
      v <= '0;
      inflight <= '0;
    end else begin
      sram_en <= acc;
      sram_we <= is_st;
      if (acc) begin
        sram_addr <= ADDR_WIDTH'(sum);
        sram_wdata <= rt;
      end
      v <= nv;
      inflight <= 4'($countones(nv));
    end
  end
  always_ff @(posedge clk) begin
    d[0] <= dest;
    for (int i = 1; i <= READ_LATENCY; i++) d[i] <= d[i-1];
    f <= {f[READ_LATENCY-1:0], op[1]};
  end
  // the write-back stage is left out: that register is being written this cycle
  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < READ_LATENCY; i++)
      query_hit = query_hit | (v[i] && d[i] == query_addr && f[i] == query_float);
  end
endmodule

// File: tb/tb_sram_lsu.sv
// tb_sram_lsu: three latency variants driven in parallel, checked against an issue-log model
module tb_sram_lsu;
  localparam logic [5:0] LDI = 6'b101000, LDR = 6'b101100, FLDI = 6'b101010, FLDR = 6'b101110;
  localparam logic [5:0] STI = 6'b101001;
  logic clk = 0, rst_n = 0, inst_valid = 0, query_float = 0;
  logic [31:0] inst = 0, rs = 0, rt = 0, imm = 0, sram_rdata = 0;
  logic [4:0] query_addr = 0;
  logic en_o [3], we_o [3], wb_o [3], wf_o [3], qh_o [3];
  logic [19:0] addr_o [3];
  logic [31:0] wd_o [3], wbd_o [3];
  logic [4:0] wa_o [3];
  logic [3:0] inf_o [3];
  int checks = 0, fails = 0, n = 0;
  typedef struct {bit rstn; bit tagv; bit [4:0] dst; bit fl;} ent_t;
  ent_t lg [4096];
  bit m_en, m_we;
  bit [19:0] m_addr;
  bit [31:0] m_wd;

  function automatic int lat(int g);
    return g == 0 ? 1 : (g == 1 ? 2 : 4);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_lsu #(.READ_LATENCY(lat(g))) dut (
      .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst(inst), .rs(rs), .rt(rt),
      .imm(imm), .sram_rdata(sram_rdata), .sram_en(en_o[g]), .sram_we(we_o[g]),
      .sram_addr(addr_o[g]), .sram_wdata(wd_o[g]), .wb_enable(wb_o[g]), .wb_addr(wa_o[g]),
      .wb_float(wf_o[g]), .wb_data(wbd_o[g]), .query_addr(query_addr),
      .query_float(query_float), .query_hit(qh_o[g]), .inflight(inf_o[g]));
  end

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // a load accepted at edge k is still pending at edge n-1 if no reset edge followed it
  function automatic bit alive(int k, int last);
    if (k < 0 || !lg[k].tagv) return 0;
    for (int i = k + 1; i <= last; i++) if (!lg[i].rstn) return 0;
    return 1;
  endfunction

  always @(posedge clk) begin : logger
    bit ld, st, fl;
    bit [4:0] dst;
    bit [31:0] off;
    bit [5:0] op;
    op = inst[31:26];
    ld = 0; st = 0; fl = 0; dst = 0; off = imm;
    if (inst_valid)
      case (op)
        LDI:  begin ld = 1; dst = inst[20:16]; end
        LDR:  begin ld = 1; dst = inst[15:11]; off = rt; end
        FLDI: begin ld = 1; dst = inst[20:16]; fl = 1; end
        FLDR: begin ld = 1; dst = inst[15:11]; off = rt; fl = 1; end
        STI, 6'b101011: st = 1;
        default: ;
      endcase
    lg[n].rstn = rst_n;
    lg[n].tagv = rst_n && ld && (fl || dst != 0);
    lg[n].dst = dst;
    lg[n].fl = fl;
    if (!rst_n) begin
      m_en = 0; m_we = 0; m_addr = 0; m_wd = 0;
    end else begin
      m_en = ld || st;
      m_we = st;
      if (ld || st) begin
        m_addr = 20'(rs + off);
        m_wd = rt;
      end
    end
    n++;
  end

  always @(negedge clk) begin
    if (n > 0)
      for (int g = 0; g < 3; g++) begin
        int l, k, cnt;
        bit hit;
        l = lat(g);
        k = n - 1 - l;
        chk("sram_en", en_o[g], m_en);
        chk("sram_we", we_o[g], m_we);
        chk("sram_addr", addr_o[g], m_addr);
        chk("sram_wdata", wd_o[g], m_wd);
        chk("wb_enable", wb_o[g], alive(k, n - 1));
        if (alive(k, n - 1)) begin
          chk("wb_addr", wa_o[g], lg[k].dst);
          chk("wb_float", wf_o[g], lg[k].fl);
          chk("wb_data", wbd_o[g], sram_rdata);
        end
        cnt = 0; hit = 0;
        for (int j = 0; j <= l; j++)
          if (alive(n - 1 - j, n - 1)) begin
            cnt++;
            if (j < l && lg[n-1-j].dst == query_addr && lg[n-1-j].fl == query_float) hit = 1;
          end
        chk("inflight", inf_o[g], cnt);
        chk("query_hit", qh_o[g], hit);
      end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set(bit vld, logic [5:0] op, logic [4:0] rtf, logic [4:0] rdf,
                     logic [31:0] a, logic [31:0] b, logic [31:0] c);
    inst_valid = vld;
    inst = {op, 5'd0, rtf, rdf, 11'd0};
    rs = a; rt = b; imm = c;
  endtask

  initial begin
    tick; tick;
    chk("rst_en", en_o[1], 0);
    chk("rst_addr", addr_o[1], 0);
    chk("rst_inflight", inf_o[1], 0);
    chk("rst_wb", wb_o[1], 0);
    rst_n = 1;
    set(1, LDI, 3, 0, 32'h100, 0, 32'h10);
    sram_rdata = 32'h12345678;
    tick;
    chk("ldi_en", en_o[1], 1);
    chk("ldi_we", we_o[1], 0);
    chk("ldi_addr", addr_o[1], 20'h110);
    inst_valid = 0;
    tick;
    chk("lat1_wb", wb_o[0], 1);
    tick;
    chk("ldi_wb", wb_o[1], 1);
    chk("ldi_wb_addr", wa_o[1], 3);
    chk("ldi_wb_float", wf_o[1], 0);
    chk("ldi_wb_data", wbd_o[1], 32'h12345678);
    repeat (4) tick;
    set(1, STI, 0, 0, 32'h20, 32'hDEADBEEF, 4);
    tick;
    chk("sti_we", we_o[1], 1);
    chk("sti_addr", addr_o[1], 20'h24);
    chk("sti_wdata", wd_o[1], 32'hDEADBEEF);
    inst_valid = 0;
    tick;
    chk("sti_inflight", inf_o[1], 0);
    for (int i = 1; i <= 4; i++) begin
      set(1, FLDR, 0, 5'(i), 32'(i * 16), 32'(i), 0);
      sram_rdata = 32'(i * 3);
      tick;
      if (i == 3) begin
        chk("fldr_peak", inf_o[1], 3);
        chk("fldr_wb1", wa_o[1], 1);
        chk("fldr_fl1", wf_o[1], 1);
      end
      if (i == 4) chk("fldr_wb2", wa_o[1], 2);
    end
    inst_valid = 0;
    tick;
    chk("fldr_wb3", wa_o[1], 3);
    tick;
    chk("fldr_wb4", wa_o[1], 4);
    tick;
    chk("fldr_done", wb_o[1], 0);
    repeat (5) tick;
    query_addr = 0; query_float = 0;
    set(1, LDI, 0, 0, 32'hFFFFF, 0, 2);
    tick;
    chk("wrap_addr", addr_o[1], 20'h00001);
    chk("r0_en", en_o[1], 1);
    chk("r0_hit", qh_o[1], 0);
    inst_valid = 0;
    repeat (5) tick;
    query_addr = 7;
    set(1, LDI, 7, 0, 32'h40, 0, 0);
    #1;
    chk("hz_same", qh_o[1], 0);
    tick;
    chk("hz_t1", qh_o[1], 1);
    inst_valid = 0;
    tick;
    chk("hz_t2", qh_o[1], 1);
    tick;
    chk("hz_t3", qh_o[1], 0);
    chk("hz_wb", wb_o[1], 1);
    repeat (3) tick;
    query_float = 1;
    set(1, LDI, 7, 0, 32'h44, 0, 0);
    tick;
    chk("hz_fl", qh_o[1], 0);
    inst_valid = 0;
    tick;
    chk("hz_fl2", qh_o[1], 0);
    repeat (5) tick;
    set(1, 6'b000000, 9, 9, 1, 2, 3);
    tick;
    set(0, LDI, 5, 0, 1, 2, 3);
    tick;
    query_addr = 0;
    set(1, FLDI, 0, 0, 32'h80, 0, 5);
    tick;
    chk("f0_hit", qh_o[1], 1);
    inst_valid = 0;
    repeat (6) tick;
    set(1, LDI, 9, 0, 32'h10, 0, 1);
    tick;
    set(1, LDR, 0, 10, 32'h10, 2, 0);
    tick;
    inst_valid = 0;
    rst_n = 0;
    tick;
    rst_n = 1;
    for (int g = 0; g < 3; g++) begin
      chk("mid_rst_inflight", inf_o[g], 0);
      chk("mid_rst_en", en_o[g], 0);
    end
    repeat (5) tick;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
